dm_responder: RTL and testbench

Data-memory responder for the pipelined MIPS core: the memory-side end of the M-stage load/store interface, replacing the zero-latency DM array with a handshaked slave. It accepts one word-aligned access at a time over a valid/ready request channel, waits a fixed latency, commits byte-enabled writes or fetches read data, and returns a response that is held until the core takes it. It emits the standard write trace line on every committed store so grader comparison is unchanged.

---
 rtl/dm_responder.sv | 178 +++++++++++++++++
 tb/tb_dm_responder.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/dm_responder.sv
// dm_responder: handshaked data-memory slave for the pipelined MIPS core.
// It accepts one word-aligned access at a time and waits a fixed latency.
// It then commits a byte-enabled store or fetches the read word, and holds
// the response until the core takes it. Committed stores print the write trace.
module dm_responder #(
    parameter int DEPTH_WORDS = 3072,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [3:0]  req_be,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [3:0]  cnt_r;
    logic        we_r;
    logic [3:0]  be_r;
    logic [29:0] idx_r;
    logic [31:0] wdata_r;
    logic [31:0] pc_r;
    logic        resp_valid_r;
    logic        resp_err_r;
    logic [31:0] resp_rdata_r;
    logic [31:0] mem_r [DEPTH_WORDS];

    logic        accept_s;
    logic        commit_s;
    logic        err_s;
    logic        rsp_done_s;
    logic        mem_wr_s;
    logic [31:0] old_word_s;
    logic [31:0] merged_s;

    // Byte-lane merge: lanes with an enable take the new data, others keep the old word.
    function automatic logic [31:0] merge_word(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  be);
        logic [31:0] m;
        m = old_w;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                m[8*i +: 8] = new_w[8*i +: 8];
            end else begin
                m[8*i +: 8] = old_w[8*i +: 8];
            end
        end
        return m;
    endfunction

    // The request side depends on the state alone, so the core never sees a combinational loop through req_valid.
    assign req_ready  = (state_r == S_IDLE);
    assign resp_valid = resp_valid_r;
    assign resp_rdata = resp_rdata_r;
    assign resp_err   = resp_err_r;

    // Handshake qualifiers, range check and merged store word for the captured access.
    always_comb begin
        accept_s   = (state_r == S_IDLE) && req_valid;
        commit_s   = (state_r == S_WAIT) && (cnt_r == 4'd0);
        rsp_done_s = (state_r == S_RESP) && resp_ready;
        err_s      = (idx_r >= 30'(DEPTH_WORDS));
        if (err_s) begin
            old_word_s = 32'd0;
        end else begin
            old_word_s = mem_r[idx_r[AW-1:0]];
        end
        merged_s   = merge_word(old_word_s, wdata_r, be_r);
        mem_wr_s   = commit_s && we_r && !err_s && (be_r != 4'd0);
    end

    // Next-state logic: IDLE -> WAIT on accept, WAIT -> RESP at commit, RESP -> IDLE on the response handshake.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (accept_s) begin
                    state_s = S_WAIT;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_WAIT: begin
                if (commit_s) begin
                    state_s = S_RESP;
                end else begin
                    state_s = S_WAIT;
                end
            end
            S_RESP: begin
                if (rsp_done_s) begin
                    state_s = S_IDLE;
                end else begin
                    state_s = S_RESP;
                end
            end
            default: state_s = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Request capture, latency countdown and the held response registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r        <= 4'd0;
            we_r         <= 1'b0;
            be_r         <= 4'd0;
            idx_r        <= 30'd0;
            wdata_r      <= 32'd0;
            pc_r         <= 32'd0;
            resp_valid_r <= 1'b0;
            resp_err_r   <= 1'b0;
            resp_rdata_r <= 32'd0;
        end else begin
            if (accept_s) begin
                we_r    <= req_we;
                be_r    <= req_be;
                idx_r   <= req_addr[31:2];
                wdata_r <= req_wdata;
                pc_r    <= req_pc;
                cnt_r   <= 4'(LATENCY - 1);
            end else if ((state_r == S_WAIT) && (cnt_r != 4'd0)) begin
                cnt_r <= cnt_r - 4'd1;
            end
            if (commit_s) begin
                resp_valid_r <= 1'b1;
                resp_err_r   <= err_s;
                // Stores and out-of-range accesses return zero data.
                resp_rdata_r <= (we_r || err_s) ? 32'd0 : old_word_s;
            end else if (rsp_done_s) begin
                resp_valid_r <= 1'b0;
                resp_err_r   <= 1'b0;
                resp_rdata_r <= 32'd0;
            end
        end
    end

    // Memory array: cleared on reset, otherwise written at the commit edge of an in-range store with lanes enabled.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem_r[i] <= 32'd0;
            end
        end else if (mem_wr_s) begin
            mem_r[idx_r[AW-1:0]] <= merged_s;
`ifndef SYNTHESIS
            $write("%0t@%08h: *%08h <= %08h\n", $time, pc_r, {idx_r, 2'b00}, merged_s);
`endif
        end
    end

endmodule

// File: tb/tb_dm_responder.sv
// Self-checking bench for dm_responder: directed test-plan steps followed by
// randomized accesses, checked against a word-indexed associative-array model.
module tb_dm_responder;

    localparam int DEPTH = 3072;
    localparam int LAT   = 2;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [3:0]  req_be;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] req_pc;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int checks = 0;
    int errors = 0;

    logic [31:0] model [int unsigned];

    dm_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_be     (req_be),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_pc     (req_pc),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rd_model(input int unsigned w);
        if (model.exists(w)) return model[w];
        return 32'd0;
    endfunction

    // One complete access, entered and left at a negedge; stall = cycles resp_ready stays low after resp_valid rises.
    task automatic access(input logic we, input logic [3:0] be, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] pc, input int stall);
        int          edges;
        int unsigned w;
        logic        exp_e;
        logic [31:0] exp_d;
        logic [31:0] cur;
        logic [31:0] mask;
        w     = addr[31:2];
        exp_e = (w >= DEPTH);
        exp_d = 32'd0;
        if (we) begin
            if (!exp_e && be != 4'd0) begin
                cur = rd_model(w);
                for (int i = 0; i < 4; i++) begin
                    mask = 32'hFF << (8 * i);
                    if (be[i]) cur = (cur & ~mask) | (wdata & mask);
                end
                model[w] = cur;
            end
        end else if (!exp_e) begin
            exp_d = rd_model(w);
        end
        chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_be     = be;
        req_addr   = addr;
        req_wdata  = wdata;
        req_pc     = pc;
        resp_ready = (stall == 0);
        @(negedge clk);
        // Scramble the request fields so that a responder not capturing them at accept is exposed.
        req_valid = 1'b0;
        req_we    = 1'($urandom);
        req_be    = 4'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
        edges = 0;
        while (resp_valid !== 1'b1 && edges < 40) begin
            chk("req_ready_wait", {31'd0, req_ready}, 32'd0);
            @(negedge clk);
            edges++;
        end
        chk("latency", edges, LAT);
        for (int i = 0; i < stall; i++) begin
            chk("stall_valid", {31'd0, resp_valid}, 32'd1);
            chk("stall_rdata", resp_rdata, exp_d);
            chk("stall_ready", {31'd0, req_ready}, 32'd0);
            @(negedge clk);
        end
        chk("resp_valid", {31'd0, resp_valid}, 32'd1);
        chk("resp_rdata", resp_rdata, exp_d);
        chk("resp_err", {31'd0, resp_err}, {31'd0, exp_e});
        chk("resp_ready_busy", {31'd0, req_ready}, 32'd0);
        resp_ready = 1'b1;
        @(negedge clk);
        chk("post_valid", {31'd0, resp_valid}, 32'd0);
        chk("post_rdata", resp_rdata, 32'd0);
        chk("post_err", {31'd0, resp_err}, 32'd0);
        chk("post_ready", {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        int unsigned idx;
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_be     = 4'd0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        req_pc     = 32'd0;
        resp_ready = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        model.delete();

        // Reset state and idle load.
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_err", {31'd0, resp_err}, 32'd0);
        access(1'b0, 4'h0, 32'h0000_0010, 32'd0, 32'h0000_1000, 0);

        // Store then load.
        access(1'b1, 4'hF, 32'h0000_0004, 32'h1234_5678, 32'h0000_3000, 0);
        access(1'b0, 4'h0, 32'h0000_0004, 32'd0, 32'h0000_3004, 0);
        chk("raw_model", rd_model(1), 32'h1234_5678);

        // Partial write, read back through a misaligned byte address of the same word.
        access(1'b1, 4'hF, 32'h0000_0008, 32'hAABB_CCDD, 32'h0000_3008, 0);
        access(1'b1, 4'b0101, 32'h0000_0008, 32'h1122_3344, 32'h0000_300C, 0);
        chk("partial_model", rd_model(2), 32'hAA22_CC44);
        access(1'b0, 4'h0, 32'h0000_0008, 32'd0, 32'h0000_3010, 0);
        access(1'b0, 4'h0, 32'h0000_000B, 32'd0, 32'h0000_3014, 0);

        // Backpressure: resp_ready low 5 cycles.
        access(1'b0, 4'h0, 32'h0000_0008, 32'd0, 32'h0000_3018, 5);

        // Range boundary: last valid word, then first invalid word.
        access(1'b1, 4'hF, 32'h0000_2FFC, 32'hCAFE_F00D, 32'h0000_301C, 0);
        access(1'b0, 4'h0, 32'h0000_2FFC, 32'd0, 32'h0000_3020, 1);
        access(1'b1, 4'hF, 32'h0000_3000, 32'h5555_AAAA, 32'h0000_3024, 0);
        access(1'b0, 4'h0, 32'h0000_3000, 32'd0, 32'h0000_3028, 0);
        access(1'b0, 4'h0, 32'h0000_0000, 32'd0, 32'h0000_302C, 0);

        // Store with no lanes enabled leaves the word untouched.
        access(1'b1, 4'h0, 32'h0000_0004, 32'hFFFF_FFFF, 32'h0000_3030, 0);
        access(1'b0, 4'h0, 32'h0000_0004, 32'd0, 32'h0000_3034, 0);

        // Randomized accesses around both ends of the array.
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 4))
                0, 1:    idx = $urandom_range(0, 7);
                2, 3:    idx = $urandom_range(DEPTH - 4, DEPTH + 3);
                default: idx = 30'h3FFF_FFF0;
            endcase
            access(1'($urandom), 4'($urandom), {idx[29:0], 2'($urandom)}, $urandom,
                   $urandom, int'($urandom_range(0, 3)));
        end

        // Reset while a store to 0x4 sits in WAIT: store discarded, memory cleared.
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_be     = 4'hF;
        req_addr   = 32'h0000_0004;
        req_wdata  = 32'hDEAD_BEEF;
        req_pc     = 32'h0000_4000;
        resp_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        chk("mid_in_wait", {31'd0, req_ready}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model.delete();
        chk("mid_valid", {31'd0, resp_valid}, 32'd0);
        chk("mid_rdata", resp_rdata, 32'd0);
        chk("mid_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        chk("mid_no_commit", {31'd0, resp_valid}, 32'd0);
        access(1'b0, 4'h0, 32'h0000_0004, 32'd0, 32'h0000_4004, 0);
        access(1'b0, 4'h0, 32'h0000_0008, 32'd0, 32'h0000_4008, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
